// File: rtl/sweep_sequencer.sv
// Triangle-sweep controller for an up/down counter: clear, count up to peak, dwell, count down, repeat.
// Optional build macro SWEEP_SEQ_CHECK_EN adds an expected-count tracker and a sticky err flag.
module sweep_sequencer #(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 8,
    parameter int REP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  peak,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [REP_W-1:0]  reps,
    input  logic [WIDTH-1:0]  count_in,
    output logic              cnt_rst,
    output logic              cnt_enable,
    output logic              cnt_direction,
    output logic              busy,
    output logic              done,
    output logic [REP_W-1:0]  rep_count,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_UP,
        S_HOLD,
        S_DOWN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [HOLD_W:0]   HOLD_ONE = (HOLD_W + 1)'(1);
    localparam logic [REP_W:0]    REP_ONE  = (REP_W + 1)'(1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]  peak_q;
    logic [HOLD_W-1:0] hold_q;
    logic [REP_W-1:0]  reps_q;
    logic [HOLD_W:0]   hold_cnt;
    logic [REP_W:0]    reps_eff;
    logic [REP_W:0]    rep_next_w;
    logic [WIDTH-1:0]  count_inc;
    logic              accept;
    logic              in_sweep;
    logic              up_last;
    logic              hold_last;
    logic              rep_end;
    logic              mismatch;

    // Command handshake: start is a one-cycle request taken only in IDLE;
    // done is a one-cycle pulse after the last repetition, never after an abort.
    assign accept     = (state == S_IDLE) && start;
    assign in_sweep   = (state == S_CLEAR) || (state == S_UP) ||
                        (state == S_HOLD)  || (state == S_DOWN);
    assign count_inc  = count_in + CNT_ONE;
    assign up_last    = (count_inc == peak_q);
    assign hold_last  = (hold_cnt == {1'b0, hold_q});
    assign reps_eff   = (reps_q == '0) ? REP_ONE : {1'b0, reps_q};
    assign rep_next_w = {1'b0, rep_count} + REP_ONE;

    always_comb begin
        state_next = state;
        rep_end    = 1'b0;
        case (state)
            S_IDLE:  if (start) state_next = S_CLEAR;
            S_CLEAR: state_next = (peak_q != '0) ? S_UP : S_HOLD;
            S_UP:    if (up_last) state_next = S_HOLD;
            S_HOLD: begin
                if (hold_last) begin
                    if (peak_q != '0) state_next = S_DOWN;
                    else              rep_end    = 1'b1;
                end
            end
            S_DOWN:  if (count_in == CNT_ONE) rep_end = 1'b1;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // Later repetitions skip CLEAR: the counter already sits at 0 after DOWN.
        if (rep_end) begin
            if (rep_next_w < reps_eff) state_next = (peak_q != '0) ? S_UP : S_HOLD;
            else                       state_next = S_DONE;
        end
        if (in_sweep && (abort || mismatch)) begin
            state_next = S_IDLE;
            rep_end    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            peak_q    <= '0;
            hold_q    <= '0;
            reps_q    <= '0;
            hold_cnt  <= '0;
            rep_count <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                peak_q    <= peak;
                hold_q    <= hold_cycles;
                reps_q    <= reps;
                rep_count <= '0;
            end else if (rep_end) begin
                rep_count <= rep_next_w[REP_W-1:0];
            end
            // Clearing on the last dwell cycle lets a HOLD->HOLD repetition restart cleanly.
            hold_cnt <= ((state == S_HOLD) && !hold_last) ? hold_cnt + HOLD_ONE : '0;
        end
    end

    assign cnt_rst       = (state == S_CLEAR);
    assign cnt_enable    = (state == S_UP) || (state == S_DOWN);
    assign cnt_direction = (state == S_UP);
    assign busy          = in_sweep;
    assign done          = (state == S_DONE);

`ifdef SWEEP_SEQ_CHECK_EN
    logic [WIDTH-1:0] exp_cnt;
    logic             err_q;

    assign mismatch = ((state == S_UP) || (state == S_HOLD) || (state == S_DOWN)) &&
                      (count_in != exp_cnt);
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: exp_cnt <= '0;
                S_UP:    exp_cnt <= exp_cnt + CNT_ONE;
                S_DOWN:  exp_cnt <= exp_cnt - CNT_ONE;
                default: exp_cnt <= exp_cnt;
            endcase
            if (accept)        err_q <= 1'b0;
            else if (mismatch) err_q <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: a behavioural counter plus a per-cycle expected trace built from the sweep rules.
module tb_sweep_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] peak = '0;
    logic [7:0] hold_cycles = '0;
    logic [3:0] reps = '0;
    logic [7:0] count_in;
    logic       cnt_rst, cnt_enable, cnt_direction, busy, done, err;
    logic [3:0] rep_count;

    logic [7:0] cnt = '0;
    logic       force_en = 1'b0;
    logic [7:0] force_val = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [17:0] exp_q[$];
    logic [17:0] mask_q[$];

    sweep_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .peak          (peak),
        .hold_cycles   (hold_cycles),
        .reps          (reps),
        .count_in      (count_in),
        .cnt_rst       (cnt_rst),
        .cnt_enable    (cnt_enable),
        .cnt_direction (cnt_direction),
        .busy          (busy),
        .done          (done),
        .rep_count     (rep_count),
        .err           (err)
    );

    // Clock and the attached 8-bit up/down counter (synchronous clear).
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_rst)         cnt <= '0;
        else if (cnt_enable) cnt <= cnt_direction ? cnt + 8'd1 : cnt - 8'd1;
    end

    assign count_in = force_en ? force_val : cnt;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] pack(input logic rs, input logic en, input logic dr,
                                         input logic bz, input logic dn, input logic er,
                                         input logic [3:0] rc, input logic [7:0] c);
        return {rs, en, dr, bz, dn, er, rc, c};
    endfunction

    function automatic logic [17:0] obs_vec();
        return {cnt_rst, cnt_enable, cnt_direction, busy, done, err, rep_count, count_in};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference trace: one CLEAR, then R triangles of peak up, hold+1 dwell, peak down, then DONE.
    task automatic build_model(input int pk, input int hd, input int rp);
        int r;
        r = (rp == 0) ? 1 : rp;
        exp_q.push_back(pack(1, 0, 0, 1, 0, 0, 4'd0, 8'd0));
        mask_q.push_back(18'h3FF00);
        for (int rep = 0; rep < r; rep++) begin
            for (int k = 0; k < pk; k++) begin
                exp_q.push_back(pack(0, 1, 1, 1, 0, 0, 4'(rep), 8'(k)));
                mask_q.push_back(18'h3FFFF);
            end
            for (int h = 0; h <= hd; h++) begin
                exp_q.push_back(pack(0, 0, 0, 1, 0, 0, 4'(rep), 8'(pk)));
                mask_q.push_back(18'h3FFFF);
            end
            for (int k = 0; k < pk; k++) begin
                exp_q.push_back(pack(0, 1, 0, 1, 0, 0, 4'(rep), 8'(pk - k)));
                mask_q.push_back(18'h3FFFF);
            end
        end
        exp_q.push_back(pack(0, 0, 0, 0, 1, 0, 4'(r), 8'd0));
        mask_q.push_back(18'h3FFFF);
    endtask

    task automatic run_sweep(input int pk, input int hd, input int rp,
                             input bit gate_start, input bit start_abort);
        logic [17:0] e;
        logic [17:0] m;
        int r;
        r = (rp == 0) ? 1 : rp;
        build_model(pk, hd, rp);
        @(negedge clk);
        peak = 8'(pk);
        hold_cycles = 8'(hd);
        reps = 4'(rp);
        start = 1'b1;
        abort = start_abort;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            check("sweep_cycle", 32'(obs_vec() & m), 32'(e & m));
            start = gate_start ? ($urandom_range(0, 3) == 0) : 1'b0;
            abort = (exp_q.size() == 0);
            peak = 8'($urandom);
            hold_cycles = 8'($urandom);
            reps = 4'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("idle_after_done", {29'd0, busy, done, cnt_enable}, 32'd0);
        check("rep_count_kept", 32'(rep_count), 32'(r));
    endtask

    initial begin
        int budget;

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(obs_vec() >> 8), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", 32'(obs_vec() >> 8), 32'd0);

        run_sweep(3, 2, 1, 0, 0);
        run_sweep(2, 0, 3, 0, 0);
        run_sweep(0, 4, 0, 0, 0);
        run_sweep(5, 1, 2, 0, 1);

        // Abort in UP: raised while the counter shows 4 so it stops at 5.
        @(negedge clk);
        peak = 8'd10; hold_cycles = 8'd3; reps = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (count_in != 8'd4 && budget < 20);
        check("abort_reach_4", 32'(count_in), 32'd4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", {28'd0, busy, done, cnt_enable, cnt_rst}, 32'd0);
        check("abort_count", 32'(count_in), 32'd5);
        check("abort_rep_count", 32'(rep_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_stays", {22'd0, busy, done, count_in}, 32'd5);
        end

        // Asynchronous reset in the middle of a dwell.
        @(negedge clk);
        peak = 8'd4; hold_cycles = 8'd6; reps = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("hold_reached", {22'd0, busy, cnt_enable, count_in}, {22'd0, 2'b10, 8'd4});
        #2 rst = 1'b0;
        #1 check("reset_mid_hold", 32'(obs_vec() >> 8), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("counter_not_reset", 32'(count_in), 32'd4);

        for (int i = 0; i < 6; i++) begin
            run_sweep($urandom_range(0, 20), $urandom_range(0, 5), $urandom_range(0, 4), 1, 0);
        end
        run_sweep(255, 0, 1, 1, 0);
        run_sweep(1, 0, 15, 1, 0);

`ifdef SWEEP_SEQ_CHECK_EN
        // Counter forced to 7 while 2 is expected in UP.
        @(negedge clk);
        peak = 8'd10; hold_cycles = 8'd0; reps = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_force_count", 32'(cnt), 32'd2);
        force_en = 1'b1;
        force_val = 8'd7;
        @(negedge clk);
        force_en = 1'b0;
        check("err_set", {29'd0, err, busy, done}, 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("err_sticky_no_done", {30'd0, err, done}, 32'd2);
        end
        run_sweep(2, 1, 1, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
